// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM state encoding,
// pipeline stall bit positions and bus constants.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_INST  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  localparam logic STOP        = 1'b1;
  localparam logic NO_STOP     = 1'b0;
  localparam logic RST_ENABLE  = 1'b1;
  localparam logic CHIP_ENABLE = 1'b1;

  localparam int STALL_IFID_BIT  = 1;
  localparam int STALL_MEMWB_BIT = 4;

  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/mem_port_timeout.sv
// Loadable down-counter for the memory access watchdog. expire is high in a
// waiting cycle once the full budget of waiting cycles has elapsed.
module mem_port_timeout
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam logic [TO_W-1:0] LOAD_VAL = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_r;

  // remaining-cycle counter: reloaded on issue, counts down while waiting
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_r <= {TO_W{1'b0}};
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (run && (cnt_r != {TO_W{1'b0}})) begin
      cnt_r <= cnt_r - TO_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = run & (cnt_r == {TO_W{1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage data access,
// with data priority, stall-safe done flags, flush draining and a timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush_i,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_ack_i,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic [DATA_W-1:0] if_inst_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o,
  output logic              bus_err_o
);

  arb_state_e        state_r, state_s;
  logic              mem_done_r, mem_done_s;
  logic              inst_done_r, inst_done_s;
  logic              ram_ce_s, ram_we_s, bus_err_s;
  logic [3:0]        ram_sel_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [DATA_W-1:0] ram_data_s, if_inst_s, mem_data_s;
  logic              issue_s, run_s, expire_s;
  logic              unused_stall_s;

  assign unused_stall_s = ^{stall[5], stall[3:2], stall[0]};
  assign run_s          = (state_r != ST_IDLE) & ~ram_ack_i;

  assign stallreq_mem_o = mem_ce_i & ~mem_done_r;
  assign stallreq_if_o  = if_ce_i & ~inst_done_r;

  mem_port_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load   (issue_s),
    .run    (run_s),
    .expire (expire_s)
  );

  // next-state and next registered-output computation
  always_comb begin
    state_s     = state_r;
    ram_ce_s    = ram_ce_o;
    ram_we_s    = ram_we_o;
    ram_sel_s   = ram_sel_o;
    ram_addr_s  = ram_addr_o;
    ram_data_s  = ram_data_o;
    if_inst_s   = if_inst_o;
    mem_data_s  = mem_data_o;
    bus_err_s   = 1'b0;
    issue_s     = 1'b0;
    mem_done_s  = mem_done_r;
    inst_done_s = inst_done_r;

    // done flags release once the owning pipeline stage advances
    if (flush_i) begin
      mem_done_s  = 1'b0;
      inst_done_s = 1'b0;
    end else begin
      if (mem_done_r && (stall[STALL_MEMWB_BIT] == NO_STOP)) begin
        mem_done_s = 1'b0;
      end else begin
        mem_done_s = mem_done_r;
      end
      if (inst_done_r && (stall[STALL_IFID_BIT] == NO_STOP)) begin
        inst_done_s = 1'b0;
      end else begin
        inst_done_s = inst_done_r;
      end
    end

    case (state_r)
      ST_IDLE: begin
        if (mem_ce_i && !mem_done_r) begin
          ram_ce_s   = CHIP_ENABLE;
          ram_we_s   = mem_we_i;
          ram_sel_s  = mem_sel_i;
          ram_addr_s = mem_addr_i;
          ram_data_s = mem_data_i;
          issue_s    = 1'b1;
          state_s    = ST_DATA;
        end else if (if_ce_i && !inst_done_r) begin
          ram_ce_s   = CHIP_ENABLE;
          ram_we_s   = 1'b0;
          ram_sel_s  = SEL_ALL;
          ram_addr_s = if_addr_i;
          issue_s    = 1'b1;
          state_s    = ST_INST;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (ram_ack_i) begin
          ram_ce_s   = 1'b0;
          mem_done_s = 1'b1;
          state_s    = ST_IDLE;
          if (!ram_we_o) begin
            mem_data_s = ram_data_i;
          end else begin
            mem_data_s = mem_data_o;
          end
        end else if (expire_s) begin
          ram_ce_s   = 1'b0;
          bus_err_s  = 1'b1;
          mem_data_s = {DATA_W{1'b0}};
          mem_done_s = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_INST: begin
        if (ram_ack_i || expire_s) begin
          ram_ce_s  = 1'b0;
          bus_err_s = ~ram_ack_i;
          state_s   = ST_IDLE;
          // a flushed fetch is discarded and will be re-requested
          if (!flush_i) begin
            if_inst_s   = ram_ack_i ? ram_data_i : {DATA_W{1'b0}};
            inst_done_s = 1'b1;
          end else begin
            if_inst_s   = if_inst_o;
          end
        end else if (flush_i) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_INST;
        end
      end
      ST_DRAIN: begin
        if (ram_ack_i || expire_s) begin
          ram_ce_s  = 1'b0;
          bus_err_s = ~ram_ack_i;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        ram_ce_s = 1'b0;
        state_s  = ST_IDLE;
      end
    endcase
  end

  // state, done flags and registered outputs
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_r     <= ST_IDLE;
      mem_done_r  <= 1'b0;
      inst_done_r <= 1'b0;
      ram_ce_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_sel_o   <= 4'h0;
      ram_addr_o  <= {ADDR_W{1'b0}};
      ram_data_o  <= {DATA_W{1'b0}};
      if_inst_o   <= {DATA_W{1'b0}};
      mem_data_o  <= {DATA_W{1'b0}};
      bus_err_o   <= 1'b0;
    end else begin
      state_r     <= state_s;
      mem_done_r  <= mem_done_s;
      inst_done_r <= inst_done_s;
      ram_ce_o    <= ram_ce_s;
      ram_we_o    <= ram_we_s;
      ram_sel_o   <= ram_sel_s;
      ram_addr_o  <= ram_addr_s;
      ram_data_o  <= ram_data_s;
      if_inst_o   <= if_inst_s;
      mem_data_o  <= mem_data_s;
      bus_err_o   <= bus_err_s;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table for fetch/data sequencing,
// hand-written sequences for stall hold, flush drain, timeout and reset.
module tb_mem_port_arbiter;

  logic        clk, rst, flush_i, if_ce_i, mem_ce_i, mem_we_i, ram_ack_i;
  logic [5:0]  stall;
  logic [3:0]  mem_sel_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_data_i, ram_data_i;
  logic        ram_ce_o, ram_we_o, stallreq_if_o, stallreq_mem_o, bus_err_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_addr_o, ram_data_o, if_inst_o, mem_data_o;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4), .TO_W(8)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush_i(flush_i),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .ram_data_i(ram_data_i), .ram_ack_i(ram_ack_i),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .if_inst_o(if_inst_o), .mem_data_o(mem_data_o),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  st;
    logic        fl, ice;
    logic [31:0] ia;
    logic        mce, mwe;
    logic [31:0] ma, wd;
    logic        ack;
    logic [31:0] rd;
    logic        ece, ewe;
    logic [3:0]  esel;
    logic [31:0] eaddr, ewd, einst, emd;
    logic        esif, esmem, eberr;
  } vec_t;

  function automatic vec_t v(
    input logic [5:0] st, input logic fl, input logic ice, input logic [31:0] ia,
    input logic mce, input logic mwe, input logic [31:0] ma, input logic [31:0] wd,
    input logic ack, input logic [31:0] rd,
    input logic ece, input logic ewe, input logic [3:0] esel, input logic [31:0] eaddr,
    input logic [31:0] ewd, input logic [31:0] einst, input logic [31:0] emd,
    input logic esif, input logic esmem, input logic eberr);
    vec_t r;
    r.st = st; r.fl = fl; r.ice = ice; r.ia = ia; r.mce = mce; r.mwe = mwe;
    r.ma = ma; r.wd = wd; r.ack = ack; r.rd = rd; r.ece = ece; r.ewe = ewe;
    r.esel = esel; r.eaddr = eaddr; r.ewd = ewd; r.einst = einst; r.emd = emd;
    r.esif = esif; r.esmem = esmem; r.eberr = eberr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [5:0] st, input logic fl, input logic ice,
                        input logic [31:0] ia, input logic mce, input logic mwe,
                        input logic [31:0] ma, input logic [31:0] wd,
                        input logic ack, input logic [31:0] rd);
    stall = st; flush_i = fl; if_ce_i = ice; if_addr_i = ia; mem_ce_i = mce;
    mem_we_i = mwe; mem_addr_i = ma; mem_data_i = wd; ram_ack_i = ack; ram_data_i = rd;
  endtask

  task automatic chk_vec(input string tag, input vec_t e);
    chk({tag, " ram_ce"}, {31'd0, ram_ce_o}, {31'd0, e.ece});
    chk({tag, " ram_we"}, {31'd0, ram_we_o}, {31'd0, e.ewe});
    chk({tag, " ram_sel"}, {28'd0, ram_sel_o}, {28'd0, e.esel});
    chk({tag, " ram_addr"}, ram_addr_o, e.eaddr);
    chk({tag, " ram_data"}, ram_data_o, e.ewd);
    chk({tag, " if_inst"}, if_inst_o, e.einst);
    chk({tag, " mem_data"}, mem_data_o, e.emd);
    chk({tag, " stallreq_if"}, {31'd0, stallreq_if_o}, {31'd0, e.esif});
    chk({tag, " stallreq_mem"}, {31'd0, stallreq_mem_o}, {31'd0, e.esmem});
    chk({tag, " bus_err"}, {31'd0, bus_err_o}, {31'd0, e.eberr});
  endtask

  vec_t tab[15];
  int   ce_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; rst = 1'b1; mem_sel_i = 4'h3;
    set_in(6'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // fetch 0x100 acked two cycles after issue
    tab[0]  = v(6'h00,1'b0,1'b1,32'h100,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,32'h0,1'b1,1'b0,1'b0);
    tab[1]  = v(6'h00,1'b0,1'b1,32'h100,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,
                1'b1,1'b0,4'hF,32'h100,32'h0,32'h0,32'h0,1'b1,1'b0,1'b0);
    tab[2]  = tab[1];
    tab[3]  = v(6'h00,1'b0,1'b1,32'h100,1'b0,1'b0,32'h0,32'h0,1'b1,32'h24010005,
                1'b1,1'b0,4'hF,32'h100,32'h0,32'h0,32'h0,1'b1,1'b0,1'b0);
    tab[4]  = v(6'h00,1'b0,1'b1,32'h104,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'hF,32'h100,32'h0,32'h24010005,32'h0,1'b0,1'b0,1'b0);
    tab[5]  = v(6'h00,1'b0,1'b0,32'h104,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'hF,32'h100,32'h0,32'h24010005,32'h0,1'b0,1'b0,1'b0);
    // data and fetch together: data first, fetch after data returns to IDLE
    tab[6]  = v(6'h00,1'b0,1'b1,32'h300,1'b1,1'b0,32'h200,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'hF,32'h100,32'h0,32'h24010005,32'h0,1'b1,1'b1,1'b0);
    tab[7]  = v(6'h00,1'b0,1'b1,32'h300,1'b1,1'b0,32'h200,32'h0,1'b1,32'h11223344,
                1'b1,1'b0,4'h3,32'h200,32'h0,32'h24010005,32'h0,1'b1,1'b1,1'b0);
    tab[8]  = v(6'h00,1'b0,1'b1,32'h300,1'b0,1'b0,32'h200,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h3,32'h200,32'h0,32'h24010005,32'h11223344,1'b1,1'b0,1'b0);
    tab[9]  = v(6'h00,1'b0,1'b1,32'h300,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,
                1'b1,1'b0,4'hF,32'h300,32'h0,32'h24010005,32'h11223344,1'b1,1'b0,1'b0);
    tab[10] = v(6'h00,1'b0,1'b1,32'h300,1'b0,1'b0,32'h0,32'h0,1'b1,32'hAABBCCDD,
                1'b1,1'b0,4'hF,32'h300,32'h0,32'h24010005,32'h11223344,1'b1,1'b0,1'b0);
    tab[11] = v(6'h00,1'b0,1'b0,32'h300,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'hF,32'h300,32'h0,32'hAABBCCDD,32'h11223344,1'b0,1'b0,1'b0);
    // write leaves mem_data_o unchanged
    tab[12] = v(6'h00,1'b0,1'b0,32'h0,1'b1,1'b1,32'h400,32'hCAFEF00D,1'b0,32'h0,
                1'b0,1'b0,4'hF,32'h300,32'h0,32'hAABBCCDD,32'h11223344,1'b0,1'b1,1'b0);
    tab[13] = v(6'h00,1'b0,1'b0,32'h0,1'b1,1'b1,32'h400,32'hCAFEF00D,1'b1,32'h55555555,
                1'b1,1'b1,4'h3,32'h400,32'hCAFEF00D,32'hAABBCCDD,32'h11223344,1'b0,1'b1,1'b0);
    tab[14] = v(6'h00,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,
                1'b0,1'b1,4'h3,32'h400,32'hCAFEF00D,32'hAABBCCDD,32'h11223344,1'b0,1'b0,1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      set_in(tab[i].st, tab[i].fl, tab[i].ice, tab[i].ia, tab[i].mce, tab[i].mwe,
             tab[i].ma, tab[i].wd, tab[i].ack, tab[i].rd);
      #1;
      chk_vec($sformatf("vec%0d", i), tab[i]);
    end

    // load acked while MEM/WB is held: no re-issue, result held
    ce_cnt = 0;
    @(negedge clk);
    set_in(6'h10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 32'h0);
    #1; chk("hold issue stallreq_mem", {31'd0, stallreq_mem_o}, 32'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      set_in((c == 5 || c == 6) ? 6'h00 : 6'h10, 1'b0, 1'b0, 32'h0, (c == 6) ? 1'b0 : 1'b1,
             1'b0, 32'h500, 32'h0, (c == 1) ? 1'b1 : 1'b0, (c == 1) ? 32'hDEADBEEF : 32'h0);
      #1;
      if (ram_ce_o) ce_cnt++;
      if (c >= 2) begin
        chk($sformatf("hold c%0d mem_data", c), mem_data_o, 32'hDEADBEEF);
        chk($sformatf("hold c%0d stallreq_mem", c), {31'd0, stallreq_mem_o}, 32'd0);
        chk($sformatf("hold c%0d ram_ce", c), {31'd0, ram_ce_o}, 32'd0);
      end
    end
    chk("hold ram_ce cycles", ce_cnt, 32'd1);

    // flush during INST: drained access discarded, refetch from new address
    @(negedge clk); set_in(6'h00, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk); set_in(6'h00, 1'b1, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1; chk("flush c1 ram_addr", ram_addr_o, 32'h600);
    @(negedge clk); set_in(6'h00, 1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1; chk("flush c2 ram_ce", {31'd0, ram_ce_o}, 32'd1);
    @(negedge clk); set_in(6'h00, 1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h99999999);
    #1; chk("flush c3 ram_ce", {31'd0, ram_ce_o}, 32'd1);
    chk("flush c3 ram_addr", ram_addr_o, 32'h600);
    @(negedge clk); set_in(6'h00, 1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1; chk("flush c4 ram_ce", {31'd0, ram_ce_o}, 32'd0);
    chk("flush c4 if_inst", if_inst_o, 32'hAABBCCDD);
    chk("flush c4 stallreq_if", {31'd0, stallreq_if_o}, 32'd1);
    @(negedge clk); set_in(6'h00, 1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h12345678);
    #1; chk("flush c5 ram_ce", {31'd0, ram_ce_o}, 32'd1);
    chk("flush c5 ram_addr", ram_addr_o, 32'h700);
    @(negedge clk); set_in(6'h00, 1'b0, 1'b0, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1; chk("flush c6 if_inst", if_inst_o, 32'h12345678);

    // unresponsive memory: abort after four waiting cycles
    @(negedge clk); set_in(6'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h800, 32'h0, 1'b0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      chk($sformatf("tmo c%0d ram_ce", c), {31'd0, ram_ce_o}, 32'd1);
      chk($sformatf("tmo c%0d bus_err", c), {31'd0, bus_err_o}, 32'd0);
    end
    @(negedge clk); #1;
    chk("tmo c5 ram_ce", {31'd0, ram_ce_o}, 32'd0);
    chk("tmo c5 bus_err", {31'd0, bus_err_o}, 32'd1);
    chk("tmo c5 mem_data", mem_data_o, 32'h0);
    chk("tmo c5 stallreq_mem", {31'd0, stallreq_mem_o}, 32'd0);
    @(negedge clk); set_in(6'h00, 1'b0, 1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1; chk("tmo c6 bus_err", {31'd0, bus_err_o}, 32'd0);
    @(negedge clk); set_in(6'h00, 1'b0, 1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0F0F0F0F);
    #1; chk("tmo c7 ram_ce", {31'd0, ram_ce_o}, 32'd1);
    chk("tmo c7 ram_addr", ram_addr_o, 32'h900);
    @(negedge clk); set_in(6'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1; chk("tmo c8 if_inst", if_inst_o, 32'h0F0F0F0F);

    // reset in the middle of a data access
    @(negedge clk); set_in(6'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA00, 32'h77, 1'b0, 32'h0);
    @(negedge clk); set_in(6'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    #1; chk("rst c1 ram_ce", {31'd0, ram_ce_o}, 32'd1);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      rst = 1'b0;
      set_in(6'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, (c == 2) ? 1'b1 : 1'b0, 32'hFFFFFFFF);
      #1;
      chk_vec($sformatf("rst c%0d", c),
              v(6'h00,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
